// File: rtl/phase_accumulator_ser.sv
// phase_accumulator_ser: NCO phase accumulator that serialises a quadrant-folded phase word for a serial sine lookup.
// Latency: one frame is NCH+1 cycles; a frame's phase word is computed on the boundary edge that opens it.
// Backpressure: none; runs freely while i_en is high, and i_en low aborts the frame and clears the datapath.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   i_en     run enable (low = synchronous clear/hold)
//   i_fcw    frequency control word, captured into the shadow on i_upd
//   i_poff   phase offset, captured into the shadow on i_upd
//   i_upd    shadow capture strobe
//   o_pend   shadow update waiting for a frame boundary
//   o_vld    boundary slot (slot NCH) indicator
//   o_aout   serial phase chunk, LSB chunk first
//   o_isout  sign-invert flag for the current frame
//   o_wrap   one-cycle pulse when the accumulator carried out
// Optional: define PHACC_DITHER_EN to add 16-bit LFSR dither ahead of phase truncation.
module phase_accumulator_ser #(
  parameter int ACC_W   = 20,
  parameter int PH_W    = 12,
  parameter int CHUNK_W = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [ACC_W-1:0]   i_fcw,
  input  logic [PH_W-1:0]    i_poff,
  input  logic               i_upd,
  output logic               o_pend,
  output logic               o_vld,
  output logic [CHUNK_W-1:0] o_aout,
  output logic               o_isout,
  output logic               o_wrap
);

  localparam int NCH = PH_W / CHUNK_W;
  localparam int SW  = $clog2(NCH + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NCH);
  localparam logic [SW-1:0] SLOT_INIT = SW'(NCH - 1);

  logic [SW-1:0]    r_slot;
  logic [ACC_W-1:0] r_acc;
  logic [PH_W-1:0]  r_atmp;
  logic [ACC_W-1:0] r_fcw_act;
  logic [PH_W-1:0]  r_poff_act;
  logic [ACC_W-1:0] r_fcw_sh;
  logic [PH_W-1:0]  r_poff_sh;
  logic             r_isout;
  logic             r_wrap;
  logic             r_pend;

  logic             w_bnd;
  logic [ACC_W-1:0] w_dith;
  logic [ACC_W-1:0] w_sum;
  logic [PH_W-1:0]  w_p;
  logic [1:0]       w_q;
  logic [PH_W-1:0]  w_fold;
  logic [ACC_W:0]   w_acc_add;
  logic [CHUNK_W-1:0] w_aout;

  // Boundary edge: the clock edge that ends slot NCH while running.
  assign w_bnd = i_en && (r_slot == SLOT_LAST);

`ifdef PHACC_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_fb;

  // Fibonacci LFSR, taps 16,14,13,11.
  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= 16'hACE1;
    end else if (!i_en) begin
      r_lfsr <= 16'hACE1;
    end else if (w_bnd) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  // Dither only touches the bits discarded by truncation.
  if (ACC_W > PH_W) begin : g_dith
    assign w_dith = {{PH_W{1'b0}}, r_lfsr[ACC_W-PH_W-1:0]};
  end else begin : g_nodith
    assign w_dith = '0;
  end
`else
  assign w_dith = '0;
`endif

  // Phase truncation plus offset, both wrapping modulo their widths.
  assign w_sum     = r_acc + w_dith;
  assign w_p       = w_sum[ACC_W-1 -: PH_W] + r_poff_act;
  assign w_q       = w_p[PH_W-1 -: 2];
  assign w_acc_add = {1'b0, r_acc} + {1'b0, r_fcw_act};

  // Quadrant fold: quadrants 1 and 2 are mirrored so the lookup only
  // needs to cover half a period; ISout carries the sign.
  always_comb begin
    w_fold = w_p;
    case (w_q)
      2'b01:   w_fold = {2'b11, w_p[PH_W-3:0]};
      2'b10:   w_fold = {2'b00, w_p[PH_W-3:0]};
      default: w_fold = w_p;
    endcase
  end

  // Chunk select; the boundary slot (and any unused code) reads as zero.
  always_comb begin
    w_aout = '0;
    for (int k = 0; k < NCH; k++) begin
      if (r_slot == SW'(k)) begin
        w_aout = r_atmp[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  // Shadow registers follow i_upd regardless of i_en.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fcw_sh  <= '0;
      r_poff_sh <= '0;
    end else if (i_upd) begin
      r_fcw_sh  <= i_fcw;
      r_poff_sh <= i_poff;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot     <= SLOT_INIT;
      r_acc      <= '0;
      r_atmp     <= '0;
      r_fcw_act  <= '0;
      r_poff_act <= '0;
      r_isout    <= 1'b0;
      r_wrap     <= 1'b0;
      r_pend     <= 1'b0;
    end else if (!i_en) begin
      // Idle: active values track the shadow directly, nothing pending.
      r_slot     <= SLOT_INIT;
      r_acc      <= '0;
      r_atmp     <= '0;
      r_wrap     <= 1'b0;
      r_fcw_act  <= r_fcw_sh;
      r_poff_act <= r_poff_sh;
      r_pend     <= 1'b0;
    end else begin
      r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + SW'(1);
      r_wrap <= 1'b0;
      // A fresh capture always leaves a pending transfer, even on the
      // boundary edge, so the new values land one frame later.
      if (i_upd) begin
        r_pend <= 1'b1;
      end else if (w_bnd) begin
        r_pend <= 1'b0;
      end
      if (w_bnd) begin
        r_atmp  <= w_fold;
        r_isout <= w_q[1] ^ w_q[0];
        r_acc   <= w_acc_add[ACC_W-1:0];
        r_wrap  <= w_acc_add[ACC_W];
        if (r_pend && !i_upd) begin
          r_fcw_act  <= r_fcw_sh;
          r_poff_act <= r_poff_sh;
        end
      end
    end
  end

  assign o_pend  = r_pend;
  assign o_vld   = (r_slot == SLOT_LAST);
  assign o_aout  = w_aout;
  assign o_isout = r_isout;
  assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_phase_accumulator_ser.sv
// tb_phase_accumulator_ser: self-checking bench for phase_accumulator_ser with default parameters.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_phase_accumulator_ser;

  localparam int ACC_W   = 20;
  localparam int PH_W    = 12;
  localparam int CHUNK_W = 2;
  localparam int NCH     = PH_W / CHUNK_W;
  localparam longint ACCM = longint'(1) << ACC_W;
  localparam longint PHM  = longint'(1) << PH_W;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b1;
  logic               en    = 1'b0;
  logic               upd   = 1'b0;
  logic [ACC_W-1:0]   fcw   = '0;
  logic [PH_W-1:0]    poff  = '0;
  logic               pend;
  logic               vld;
  logic [CHUNK_W-1:0] aout;
  logic               isout;
  logic               wrap;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  phase_accumulator_ser #(.ACC_W(ACC_W), .PH_W(PH_W), .CHUNK_W(CHUNK_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_fcw   (fcw),
    .i_poff  (poff),
    .i_upd   (upd),
    .o_pend  (pend),
    .o_vld   (vld),
    .o_aout  (aout),
    .o_isout (isout),
    .o_wrap  (wrap)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_n counts enabled cycles since the last idle/reset; the frame
  // position follows from it arithmetically.
  longint m_acc = 0, m_fcw = 0, m_poff = 0, m_sh_fcw = 0, m_sh_poff = 0, m_word = 0;
  bit     m_pend = 0, m_is = 0, m_wrap = 0;
  int     m_n = 0;
  longint mp, mq, mlo, msum;

  function automatic int m_slot();
    return (m_n + NCH - 1) % (NCH + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_fcw = 0; m_poff = 0; m_sh_fcw = 0; m_sh_poff = 0;
      m_word = 0; m_pend = 0; m_is = 0; m_wrap = 0; m_n = 0;
    end else if (!en) begin
      m_n = 0; m_acc = 0; m_word = 0; m_wrap = 0; m_pend = 0;
      m_fcw = m_sh_fcw; m_poff = m_sh_poff;
      if (upd) begin m_sh_fcw = longint'(fcw); m_sh_poff = longint'(poff); end
    end else begin
      m_wrap = 0;
      if (m_slot() == NCH) begin
        mp  = ((m_acc >> (ACC_W - PH_W)) + m_poff) % PHM;
        mq  = mp / (PHM / 4);
        mlo = mp % (PHM / 4);
        if (mq == 1)      m_word = 3 * (PHM / 4) + mlo;
        else if (mq == 2) m_word = mlo;
        else              m_word = mp;
        m_is   = (mq == 1) || (mq == 2);
        msum   = m_acc + m_fcw;
        m_wrap = (msum >= ACCM);
        m_acc  = msum % ACCM;
        if (m_pend && !upd) begin
          m_fcw = m_sh_fcw; m_poff = m_sh_poff; m_pend = 0;
        end
      end
      if (upd) begin
        m_sh_fcw = longint'(fcw); m_sh_poff = longint'(poff); m_pend = 1;
      end
      m_n++;
    end
  end

  // Every-cycle comparison against the model.
  int cs;
  always @(negedge clk) begin
    cs = m_slot();
    chk("cmp_vld",   64'(vld),   64'(cs == NCH));
    chk("cmp_aout",  64'(aout),  (cs == NCH) ? 64'd0 : 64'((m_word >> (CHUNK_W * cs)) & ((1 << CHUNK_W) - 1)));
    chk("cmp_isout", 64'(isout), 64'(m_is));
    chk("cmp_wrap",  64'(wrap),  64'(m_wrap));
    chk("cmp_pend",  64'(pend),  64'(m_pend));
  end

  // ---------------- helpers ----------------
  task automatic wait_vld();
    int g = 0;
    while (vld !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    chk("wait_vld", 64'(vld), 64'd1);
  endtask

  // Collects the NCH chunks following a boundary slot into one word.
  task automatic get_frame(output logic [PH_W-1:0] w, output logic is);
    w = '0; is = 1'b0;
    wait_vld();
    for (int k = 0; k < NCH; k++) begin
      @(negedge clk);
      w[k*CHUNK_W +: CHUNK_W] = aout;
      is = isout;
    end
  endtask

  task automatic load(input logic [ACC_W-1:0] f, input logic [PH_W-1:0] p);
    @(negedge clk); en = 1'b0; upd = 1'b1; fcw = f; poff = p;
    @(negedge clk); upd = 1'b0;
    @(negedge clk); en = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation ran past its time limit, required to finish earlier");
    $fatal(1);
  end

  logic [PH_W-1:0] w0, w1, w2, w3, d;
  logic            is0;

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld", 64'(vld), 64'd0);
    chk("rst_aout", 64'(aout), 64'd0);
    chk("rst_pend", 64'(pend), 64'd0);
    chk("rst_isout", 64'(isout), 64'd0);
    chk("rst_wrap", 64'(wrap), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First frames
    load(20'h01000, 12'h000);
    chk("t1_vld_c1", 64'(vld), 64'd0);
    @(negedge clk);
    chk("t1_vld_c2", 64'(vld), 64'd1);
    get_frame(w0, is0);
    chk("t1_frame1", 64'(w0), 64'h000);
    get_frame(w1, is0);
    chk("t1_frame2", 64'(w1), 64'h010);
    chk("t1_frame2_is", 64'(is0), 64'd0);
    chk("t1_model_word", 64'(m_word), 64'h010);

    // Quadrant fold
    load(20'h0, 12'h400);
    get_frame(w0, is0);
    chk("t2_q1_word", 64'(w0), 64'hC00);
    chk("t2_q1_is", 64'(is0), 64'd1);
    chk("t2_model_is", 64'(m_is), 64'd1);
    load(20'h0, 12'h800);
    get_frame(w0, is0);
    chk("t2_q2_word", 64'(w0), 64'h000);
    chk("t2_q2_is", 64'(is0), 64'd1);
    load(20'h0, 12'hC00);
    get_frame(w0, is0);
    chk("t2_q3_word", 64'(w0), 64'hC00);
    chk("t2_q3_is", 64'(is0), 64'd0);

    // Mid-frame update in slot 2
    load(20'h01000, 12'h000);
    get_frame(w0, is0);
    @(negedge clk);
    chk("t3_bnd_vld", 64'(vld), 64'd1);
    repeat (3) @(negedge clk);
    upd = 1'b1; fcw = 20'h02000;
    @(negedge clk);
    upd = 1'b0;
    chk("t3_pend_slot3", 64'(pend), 64'd1);
    repeat (3) @(negedge clk);
    chk("t3_pend_bnd_vld", 64'(vld), 64'd1);
    chk("t3_pend_bnd", 64'(pend), 64'd1);
    @(negedge clk);
    chk("t3_pend_after", 64'(pend), 64'd0);
    get_frame(w2, is0);
    get_frame(w3, is0);
    chk("t3_w0", 64'(w0), 64'h000);
    chk("t3_w2", 64'(w2), 64'h030);
    d = w3 - w2;
    chk("t3_step_new", 64'(d), 64'h020);

    // Wrap: carry on every second boundary
    load(20'h80000, 12'h000);
    for (int f = 0; f < 4; f++) begin
      wait_vld();
      @(negedge clk);
      chk("t4_wrap_pulse", 64'(wrap), 64'(f % 2));
      @(negedge clk);
      chk("t4_wrap_clear", 64'(wrap), 64'd0);
    end

    // En abort in slot 3
    load(20'h01000, 12'h000);
    get_frame(w0, is0);
    get_frame(w0, is0);
    wait_vld();
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("t5_abort_vld", 64'(vld), 64'd0);
    chk("t5_abort_aout", 64'(aout), 64'd0);
    en = 1'b1;
    @(negedge clk);
    chk("t5_re_vld", 64'(vld), 64'd1);
    get_frame(w0, is0);
    chk("t5_re_f1", 64'(w0), 64'h000);
    get_frame(w1, is0);
    chk("t5_re_f2", 64'(w1), 64'h010);

    // Async reset with an update pending
    load(20'h01000, 12'h523);
    get_frame(w0, is0);
    chk("t6_pre_is", 64'(is0), 64'd1);
    @(negedge clk);
    upd = 1'b1; fcw = 20'h03000;
    @(negedge clk);
    upd = 1'b0;
    chk("t6_pend", 64'(pend), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pend", 64'(pend), 64'd0);
    chk("t6_rst_vld", 64'(vld), 64'd0);
    chk("t6_rst_aout", 64'(aout), 64'd0);
    chk("t6_rst_isout", 64'(isout), 64'd0);
    chk("t6_rst_wrap", 64'(wrap), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    get_frame(w0, is0);
    get_frame(w1, is0);
    chk("t6_post_f2", 64'(w1), 64'h000);
    chk("t6_post_is", 64'(is0), 64'd0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en   = ($urandom_range(0, 99) != 0);
      upd  = ($urandom_range(0, 15) == 0);
      fcw  = ($urandom_range(0, 3) == 0) ? ACC_W'(20'h80000 | ($urandom_range(0, 1) << 18)) : ACC_W'($urandom);
      poff = PH_W'($urandom);
      if (i == 1500) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    en = 1'b0; upd = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/phase_accumulator_ser.md
Name: phase_accumulator_ser

Overview:
- Parametrised next-generation NCO phase accumulator.
- Generalises accumulator width, output phase width and serial chunk width.
- Adds a frame-aligned shadowed FCW/phase-offset update, a phase-wrap flag and optional LFSR phase dither.
- Sits ahead of the serial sine-lookup stage: each frame it emits one quadrant-folded phase word, LSB chunk first, plus a sign-invert flag.

Parameters:
- ACC_W, 20: accumulator / FCW width.
- PH_W, 12: truncated phase width, quadrant bits included. Must be a multiple of CHUNK_W, 3 ≤ PH_W ≤ ACC_W.
- CHUNK_W, 2: serial output chunk width. NCH = PH_W/CHUNK_W (localparam); frame length = NCH+1 cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- En  in  1  run enable; low = synchronous clear/hold.
- FCW  in  ACC_W  frequency control word, captured on Upd.
- POFF  in  PH_W  phase offset, captured on Upd.
- Upd  in  1  capture strobe for FCW/POFF into shadow registers.
- Pend  out  1  shadow update waiting for a frame boundary.
- Vld  out  1  boundary slot (slot NCH) indicator.
- Aout  out  CHUNK_W  serial phase chunk.
- ISout  out  1  sign-invert flag for the current frame.
- Wrap  out  1  one-cycle pulse: accumulator carried out.

Behaviour:
- Async reset: slot=NCH-1, acc=0, Atmp=0, active FCW/POFF=0, shadow=0, ISout=0, Wrap=0, Pend=0. Outputs therefore Vld=0, Aout=0.
- En low (sync, rst_n high): slot<=NCH-1, acc<=0, Atmp<=0, Wrap<=0. ISout holds. Active<=shadow every cycle; Pend<=0.
- En high: slot counts NCH-1 → NCH → 0 → 1 … → NCH, wrapping. The first Vld occurs on the second enabled cycle.
- Vld = (slot==NCH).
- Aout is combinational:
  - Atmp[k*CHUNK_W +: CHUNK_W] while slot==k (k=0..NCH-1).
  - 0 in slot NCH. Never X.
- Boundary edge (clock edge ending slot NCH, En high), all computed from pre-edge values:
  - P = acc[ACC_W-1 -: PH_W] + active POFF, mod 2^PH_W. q = P[PH_W-1:PH_W-2].
  - Atmp <= {2'b11, P[PH_W-3:0]} if q==01; {2'b00, P[PH_W-3:0]} if q==10; else P.
  - ISout <= q[1]^q[0].
  - acc <= acc + active FCW, mod 2^ACC_W. Wrap<=1 if carry-out, else 0.
  - If Pend: active <= shadow, Pend <= 0. The new FCW is used from the next boundary add; the new POFF from the next P.
- Wrap clears on the following edge; it is one cycle wide.
- Upd high, not in reset: shadow<=FCW/POFF; Pend<=1 next cycle (when En high).
- Upd coincident with the boundary edge: shadow captures, but the transfer is deferred one frame; Pend stays 1.
- Repeated Upd before a boundary: last value wins.
- En dropped mid-frame: the frame is aborted; no partial boundary processing.

Optional Feature:
- Macro: PHACC_DITHER_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset and while En low.
  - The LFSR advances once per boundary edge.
  - The truncation uses D = lfsr[ACC_W-PH_W-1:0], zero-extended: P = (acc + D)[ACC_W-1 -: PH_W] + POFF, where the sum is ACC_W bits, mod.
  - Requires ACC_W-PH_W ≤ 16. acc itself is never dithered.
- Undefined: D=0; no LFSR logic.

Test Plan (defaults, dither off):
- Reset/first frames:
  - Stimulus: rst_n low, then FCW=0x01000, Upd pulse, En=1.
  - Response: Vld on 2nd En cycle. Frame 1 chunks 0,0,0,0,0,0. Frame 2 Atmp=0x010 → chunks 0,0,1,0,0,0; ISout=0.
- Quadrant fold:
  - Stimulus: FCW=0, POFF=0x400 loaded, En=1.
  - Response: Atmp=0xC00 → chunks 0,0,0,0,0,3; ISout=1.
  - Stimulus: POFF=0x800.
  - Response: Atmp=0x000, ISout=1. POFF=0xC00 → Atmp=0xC00, ISout=0.
- Mid-frame update:
  - Stimulus: running FCW=0x01000; Upd with FCW=0x02000 in slot 2.
  - Response: Pend=1 from slot 3 to the boundary edge, then 0. Per-frame P step is 0x010 for the current add, then 0x020.
- Wrap:
  - Stimulus: FCW=0x80000.
  - Response: acc alternates 0x80000/0x00000; Wrap pulses one cycle after every second boundary.
- En abort:
  - Stimulus: drop En in slot 3.
  - Response: next cycle Vld=0, Aout=0, acc=0. Re-enable → Vld on 2nd cycle, chunks restart from phase 0.
- Async reset mid-frame:
  - Stimulus: assert rst_n with Pend=1.
  - Response: all outputs 0 immediately, no clock needed; Pend=0; active FCW=0.
